// File: rtl/snitch_icache_data_pm.sv
// Instruction-cache data array with per-set SRAM splits, a per-set OFF/WAKING/ON
// power sequencer and an optional output register on the read path.
module snitch_icache_data_pm #(
  parameter int unsigned SET_COUNT       = 4,
  parameter int unsigned LINE_COUNT      = 128,
  parameter int unsigned LINE_WIDTH      = 128,
  parameter int unsigned NUM_SPLIT       = 2,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned WAKE_CYCLES     = 4,
  parameter type         sram_cfg_data_t = logic,
  localparam int unsigned AW             = $clog2(LINE_COUNT)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  sram_cfg_data_t                       sram_cfg_data_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [SET_COUNT-1:0]                 req_set_i,
  input  logic                                 req_write_i,
  input  logic [AW-1:0]                        req_addr_i,
  input  logic [SET_COUNT-1:0][LINE_WIDTH-1:0] req_wdata_i,
  output logic                                 rsp_valid_o,
  output logic [SET_COUNT-1:0][LINE_WIDTH-1:0] rsp_rdata_o,
  input  logic [SET_COUNT-1:0]                 sleep_req_i,
  output logic [SET_COUNT-1:0]                 pwr_en_o,
  output logic [SET_COUNT-1:0]                 pwr_on_o,
  output logic [SET_COUNT-1:0]                 set_lost_o
);
  localparam int unsigned SW = LINE_WIDTH / NUM_SPLIT;
  localparam int unsigned CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

  typedef enum logic [1:0] {PWR_OFF, PWR_WAKING, PWR_ON} pwr_state_e;

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gen_bad_latency
    $error("READ_LATENCY must be 1 or 2");
  end
  if (NUM_SPLIT == 0 || (LINE_WIDTH % NUM_SPLIT) != 0) begin : gen_bad_split
    $error("NUM_SPLIT must divide LINE_WIDTH");
  end
  if (WAKE_CYCLES < 1) begin : gen_bad_wake
    $error("WAKE_CYCLES must be at least 1");
  end

  // Inferred macros have no implementation knobs; the config port is kept for macro builds.
  logic cfg_unused;
  assign cfg_unused = ^sram_cfg_data_i;

  logic                                            accept;
  logic                                            rd_accept;
  logic [SET_COUNT-1:0]                            req_hit;
  logic [SET_COUNT-1:0]                            macro_req;
  logic [SET_COUNT-1:0]                            on_state;
  logic [SET_COUNT-1:0]                            sleep_block;
  logic [READ_LATENCY-1:0]                         valid_pipe_reg;
  logic [READ_LATENCY-1:0][SET_COUNT-1:0]          mask_pipe_reg;
  logic [SET_COUNT-1:0][NUM_SPLIT-1:0][SW-1:0]     macro_rdata;
  logic [SET_COUNT-1:0][LINE_WIDTH-1:0]            line_rdata;

  // Ready only when every addressed set is powered and settled; an empty mask is always ready.
  always_comb begin
    req_ready_o = 1'b1;
    for (int s = 0; s < SET_COUNT; s++) begin
      if (req_set_i[s] && !on_state[s]) req_ready_o = 1'b0;
    end
  end

  assign accept    = req_valid_i & req_ready_o;
  assign rd_accept = accept & ~req_write_i;
  assign req_hit   = {SET_COUNT{req_valid_i}} & req_set_i;
  assign macro_req = {SET_COUNT{accept}} & req_set_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_pipe_reg <= '0;
      mask_pipe_reg  <= '0;
    end else begin
      valid_pipe_reg[0] <= rd_accept;
      mask_pipe_reg[0]  <= rd_accept ? req_set_i : '0;
      for (int k = 1; k < READ_LATENCY; k++) begin
        valid_pipe_reg[k] <= valid_pipe_reg[k-1];
        mask_pipe_reg[k]  <= mask_pipe_reg[k-1];
      end
    end
  end

  // A set must stay powered until its macro output has been captured by the last stage.
  always_comb begin
    sleep_block = '0;
    for (int k = 0; k + 1 < READ_LATENCY; k++) begin
      sleep_block = sleep_block | mask_pipe_reg[k];
    end
  end

  for (genvar gi = 0; gi < SET_COUNT; gi++) begin : gen_set
    pwr_state_e    state_reg;
    logic [CW-1:0] cnt_reg;
    logic          lost_reg;

    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        state_reg <= PWR_OFF;
        cnt_reg   <= '0;
        lost_reg  <= 1'b0;
      end else begin
        lost_reg <= 1'b0;
        unique case (state_reg)
          PWR_OFF: begin
            if (req_hit[gi]) begin
              state_reg <= PWR_WAKING;
              cnt_reg   <= CW'(WAKE_CYCLES - 1);
            end
          end
          PWR_WAKING: begin
            if (cnt_reg == '0) state_reg <= PWR_ON;
            else               cnt_reg   <= cnt_reg - CW'(1);
          end
          PWR_ON: begin
            if (sleep_req_i[gi] && !req_hit[gi] && !sleep_block[gi]) begin
              state_reg <= PWR_OFF;
              lost_reg  <= 1'b1;
            end
          end
          default: state_reg <= PWR_OFF;
        endcase
      end
    end

    assign on_state[gi]   = (state_reg == PWR_ON);
    assign pwr_en_o[gi]   = (state_reg != PWR_OFF);
    assign pwr_on_o[gi]   = on_state[gi];
    assign set_lost_o[gi] = lost_reg;

    for (genvar gk = 0; gk < NUM_SPLIT; gk++) begin : gen_split
      logic [SW-1:0] mem [LINE_COUNT];
      logic [SW-1:0] rdata_reg;

      always_ff @(posedge clk_i) begin
        if (macro_req[gi]) begin
          if (req_write_i) mem[req_addr_i] <= req_wdata_i[gi][gk*SW +: SW];
          else             rdata_reg       <= mem[req_addr_i];
        end
      end

      assign macro_rdata[gi][gk] = rdata_reg;
    end
  end

  // The output register carries no reset; the delayed mask zeroes anything stale.
  if (READ_LATENCY == 2) begin : gen_out_reg
    logic [SET_COUNT-1:0][LINE_WIDTH-1:0] out_reg;
    always_ff @(posedge clk_i) begin
      out_reg <= macro_rdata;
    end
    assign line_rdata = out_reg;
  end else begin : gen_no_out_reg
    assign line_rdata = macro_rdata;
  end

  assign rsp_valid_o = valid_pipe_reg[READ_LATENCY-1];

  always_comb begin
    rsp_rdata_o = '0;
    for (int s = 0; s < SET_COUNT; s++) begin
      rsp_rdata_o[s] = line_rdata[s] & {LINE_WIDTH{mask_pipe_reg[READ_LATENCY-1][s]}};
    end
  end

endmodule
